div_stream_arbiter_hd: RTL and testbench
========================================

Name: div_stream_arbiter_hd

Overview:
- Shares one online (digit-serial, redundant-binary) divider datapath and its computation controller between two requesters.
- Each requester streams DIGITS (x, d) digit pairs over valid/ready and receives DIGITS quotient digits back.
- The arbiter grants a whole operation to one requester, forwards both streams, counts digits, and releases the grant after the last quotient digit is accepted.
- Requesters and the divider handshakes are decoupled; digit encoding is never inspected.

Parameters:
- DIGITS, 16, digit pairs per operation and quotient digits per operation.
- CNT_WIDTH, 5, width of the digit counters; must hold the value DIGITS.

Ports:
- clk  input  1  clock
- asyn_reset  input  1  asynchronous, active-high reset
- req0_x, req0_d  input  2 each  requester 0 dividend/divisor digit
- req0_vld  input  1  requester 0 digit valid
- req0_rdy  output  1  requester 0 digit accepted
- req0_q  output  2  quotient digit to requester 0
- req0_q_vld  output  1  quotient valid to requester 0
- req0_q_rdy  input  1  requester 0 accepts quotient
- req1_x, req1_d, req1_vld, req1_rdy, req1_q, req1_q_vld, req1_q_rdy  same as requester 0, for requester 1
- div_x, div_d  output  2 each  digits to the divider
- div_vld  output  1  digit valid to the divider
- div_rdy  input  1  divider accepts digit
- div_q  input  2  divider quotient digit
- div_q_vld  input  1  divider quotient valid
- div_q_rdy  output  1  quotient accepted from the divider
- owner  output  1  current grant holder; meaningful when busy=1
- busy  output  1  an operation is in progress
- op_done  output  1  one-cycle pulse at release

Behaviour:
- Reset values: state IDLE, owner=0, last_grant=1 (so requester 0 wins the first tie), in_cnt=0, out_cnt=0, op_done=0. All rdy/vld outputs are 0 and busy=0.
- Reset mid-operation abandons the operation immediately. No op_done is pulsed.
- States: IDLE, STREAM, RELEASE. The state register is binary-encoded.
- IDLE:
  - If only reqN_vld=1, owner<=N.
  - If both are valid, owner<=~last_grant (round robin).
  - On grant: in_cnt<=0, out_cnt<=0, go to STREAM.
  - Grant costs one cycle; no digit is transferred in IDLE.
  - In IDLE: reqN_rdy=0, div_vld=0, div_q_rdy=0, reqN_q_vld=0.
- STREAM, input path:
  - div_x/div_d = owner's digits.
  - div_vld = owner_vld & (in_cnt<DIGITS).
  - owner_rdy = div_rdy & (in_cnt<DIGITS).
  - Non-owner rdy=0.
  - in_cnt increments on each div_vld&div_rdy and saturates at DIGITS. Once saturated, further owner digits are held off (rdy=0).
- STREAM, output path:
  - owner_q = div_q; owner_q_vld = div_q_vld & (out_cnt<DIGITS).
  - div_q_rdy = owner_q_rdy & (out_cnt<DIGITS).
  - Non-owner q_vld=0.
  - out_cnt increments on each accepted quotient digit.
- Input and output transfers may occur in the same cycle; quotient digits may arrive before all inputs are sent (online delay is arbitrary).
- STREAM -> RELEASE on the cycle out_cnt becomes DIGITS. This requires in_cnt==DIGITS or in_cnt reaching DIGITS in the same cycle.
- If out_cnt completes while in_cnt<DIGITS, stay in STREAM until in_cnt reaches DIGITS.
- RELEASE (1 cycle): op_done=1, last_grant<=owner, all handshakes 0, then go to IDLE.
- busy=1 in STREAM and RELEASE.
- div_x/div_d and reqN_q data outputs are don't-care when the matching vld=0. The bench checks them only on handshake cycles.
- Requester valids must stay asserted until accepted; the arbiter does not buffer digits (zero-latency pass-through).

Test Plan:
- Only req0_vld high, div_rdy/div_q_vld/req0_q_rdy always 1, DIGITS=16 → owner=0 one cycle after the request. Exactly 16 input and 16 output transfers, then op_done pulses once, then IDLE.
- Both requesters valid from reset → requester 0 served first. Requester 1 is granted in the IDLE cycle after op_done; a third tied operation goes to requester 0.
- During requester 0's operation, toggle req1_vld and inject div_q_vld → req1_rdy=0 and req1_q_vld=0 throughout; requester 0 counts are unaffected.
- Owner keeps req0_vld=1 after 16 digits, quotient delayed 5 cycles → req0_rdy=0 after the 16th input. STREAM holds until the 16th quotient is accepted.
- Random stalls on div_rdy and req0_q_rdy (50%) → digit order preserved, counts exactly 16/16, single op_done.
- asyn_reset asserted after 7 inputs → all outputs at reset values immediately, no op_done. A fresh request restarts with in_cnt=0.

Source files
------------

// File: rtl/div_stream_arbiter_hd.sv
// Two-requester arbiter in front of one online divider. It grants a whole
// DIGITS-long operation to one requester and passes both digit streams through.
module div_stream_arbiter_hd #(
  parameter int DIGITS    = 16,
  parameter int CNT_WIDTH = 5
) (
  input  logic       clk,
  input  logic       asyn_reset,
  input  logic [1:0] req0_x,
  input  logic [1:0] req0_d,
  input  logic       req0_vld,
  output logic       req0_rdy,
  output logic [1:0] req0_q,
  output logic       req0_q_vld,
  input  logic       req0_q_rdy,
  input  logic [1:0] req1_x,
  input  logic [1:0] req1_d,
  input  logic       req1_vld,
  output logic       req1_rdy,
  output logic [1:0] req1_q,
  output logic       req1_q_vld,
  input  logic       req1_q_rdy,
  output logic [1:0] div_x,
  output logic [1:0] div_d,
  output logic       div_vld,
  input  logic       div_rdy,
  input  logic [1:0] div_q,
  input  logic       div_q_vld,
  output logic       div_q_rdy,
  output logic       owner,
  output logic       busy,
  output logic       op_done
);

  typedef enum logic [1:0] {IDLE = 2'd0, STREAM = 2'd1, RELEASE = 2'd2} state_t;

  localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(DIGITS);

  state_t               state, state_nxt;
  logic                 last_grant;
  logic [CNT_WIDTH-1:0] in_cnt, out_cnt, in_nxt, out_nxt;
  logic [1:0]           vld, q_rdy;
  logic [1:0][1:0]      x, d;
  logic                 in_open, out_open, in_fire, out_fire, grant_to;

  assign vld   = {req1_vld, req0_vld};
  assign q_rdy = {req1_q_rdy, req0_q_rdy};
  assign x     = {req1_x, req0_x};
  assign d     = {req1_d, req0_d};

  assign in_open  = (state == STREAM) && (in_cnt < LAST);
  assign out_open = (state == STREAM) && (out_cnt < LAST);
  assign in_fire  = div_vld & div_rdy;
  assign out_fire = div_q_vld & div_q_rdy;
  assign in_nxt   = in_cnt + CNT_WIDTH'(in_fire);
  assign out_nxt  = out_cnt + CNT_WIDTH'(out_fire);

  // Tie goes to whoever did not hold the last grant; otherwise the lone requester.
  assign grant_to = (&vld) ? ~last_grant : req1_vld;

  always_ff @(posedge clk or posedge asyn_reset) begin
    if (asyn_reset) state <= IDLE;
    else            state <= state_nxt;
  end

  always_ff @(posedge clk or posedge asyn_reset) begin
    if (asyn_reset) begin
      owner      <= 1'b0;
      last_grant <= 1'b1;
      in_cnt     <= '0;
      out_cnt    <= '0;
    end else begin
      case (state)
        IDLE: if (|vld) begin
          owner   <= grant_to;
          in_cnt  <= '0;
          out_cnt <= '0;
        end
        STREAM: begin
          in_cnt  <= in_nxt;
          out_cnt <= out_nxt;
        end
        RELEASE: last_grant <= owner;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|vld) state_nxt = STREAM;
      // Release only once both directions have moved all DIGITS.
      STREAM:  if (in_nxt == LAST && out_nxt == LAST) state_nxt = RELEASE;
      RELEASE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    div_x      = x[owner];
    div_d      = d[owner];
    req0_q     = div_q;
    req1_q     = div_q;
    div_vld    = in_open & vld[owner];
    div_q_rdy  = out_open & q_rdy[owner];
    req0_rdy   = in_open & ~owner & div_rdy;
    req1_rdy   = in_open & owner & div_rdy;
    req0_q_vld = out_open & ~owner & div_q_vld;
    req1_q_vld = out_open & owner & div_q_vld;
    busy       = (state != IDLE);
    op_done    = (state == RELEASE);
  end

endmodule

// File: tb/tb_div_stream_arbiter_hd.sv
// Randomized bench for div_stream_arbiter_hd against a transaction-level
// reference (grant holder, digits moved per direction, operation phase).
module tb_div_stream_arbiter_hd;
  localparam int DIGITS = 16;

  logic       clk = 1'b0, asyn_reset;
  logic [1:0] req0_x, req0_d, req1_x, req1_d, req0_q, req1_q;
  logic [1:0] div_x, div_d, div_q;
  logic       req0_vld, req0_rdy, req0_q_vld, req0_q_rdy;
  logic       req1_vld, req1_rdy, req1_q_vld, req1_q_rdy;
  logic       div_vld, div_rdy, div_q_vld, div_q_rdy;
  logic       owner, busy, op_done;

  always #5 clk = ~clk;

  div_stream_arbiter_hd #(.DIGITS(DIGITS), .CNT_WIDTH(5)) dut (
    .clk(clk), .asyn_reset(asyn_reset),
    .req0_x(req0_x), .req0_d(req0_d), .req0_vld(req0_vld), .req0_rdy(req0_rdy),
    .req0_q(req0_q), .req0_q_vld(req0_q_vld), .req0_q_rdy(req0_q_rdy),
    .req1_x(req1_x), .req1_d(req1_d), .req1_vld(req1_vld), .req1_rdy(req1_rdy),
    .req1_q(req1_q), .req1_q_vld(req1_q_vld), .req1_q_rdy(req1_q_rdy),
    .div_x(div_x), .div_d(div_d), .div_vld(div_vld), .div_rdy(div_rdy),
    .div_q(div_q), .div_q_vld(div_q_vld), .div_q_rdy(div_q_rdy),
    .owner(owner), .busy(busy), .op_done(op_done)
  );

  int n_vec = 0, n_err = 0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Stimulus: pending requester digits and pending divider quotient.
  bit         rv[2];
  logic [1:0] rx[2], rd[2];
  bit         qv;
  logic [1:0] qd;

  // Reference: phase 0 idle, 1 streaming, 2 releasing.
  int m_phase, m_owner, m_last, m_in, m_out;
  int n_in, n_out;
  int own_log[$];

  task automatic model_reset();
    m_phase = 0; m_owner = 0; m_last = 1; m_in = 0; m_out = 0;
    n_in = 0; n_out = 0;
  endtask

  task automatic chk_reset_outs(string tag);
    chk({tag, "_rdy0"}, req0_rdy, 0);
    chk({tag, "_rdy1"}, req1_rdy, 0);
    chk({tag, "_qv0"}, req0_q_vld, 0);
    chk({tag, "_qv1"}, req1_q_vld, 0);
    chk({tag, "_dvld"}, div_vld, 0);
    chk({tag, "_dqrdy"}, div_q_rdy, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, op_done, 0);
    chk({tag, "_owner"}, owner, 0);
  endtask

  task automatic drive_idle();
    req0_vld = 0; req1_vld = 0; req0_x = 0; req0_d = 0; req1_x = 0; req1_d = 0;
    req0_q_rdy = 0; req1_q_rdy = 0; div_rdy = 0; div_q_vld = 0; div_q = 0;
    rv[0] = 0; rv[1] = 0; qv = 0;
  endtask

  task automatic do_reset();
    asyn_reset = 1;
    drive_idle();
    #1 chk_reset_outs("rst");
    repeat (2) @(negedge clk);
    model_reset();
    asyn_reset = 0;
  endtask

  // One clock: present stimulus after negedge, check, then advance the model.
  task automatic cyc(int p0, int p1, int pdr, int pqv, int pqr, bit tog1 = 0);
    int o;
    bit in_open, out_open, e_dv, e_qr, dfire, qfire, qro;
    @(negedge clk);
    for (int n = 0; n < 2; n++)
      if (!rv[n] || (n == 1 && tog1)) begin
        rv[n] = $urandom_range(99) < (n == 0 ? p0 : p1);
        rx[n] = 2'($urandom);
        rd[n] = 2'($urandom);
      end
    if (!qv) begin qv = $urandom_range(99) < pqv; qd = 2'($urandom); end
    req0_vld = rv[0]; req0_x = rx[0]; req0_d = rd[0];
    req1_vld = rv[1]; req1_x = rx[1]; req1_d = rd[1];
    div_q_vld = qv; div_q = qd;
    div_rdy    = $urandom_range(99) < pdr;
    req0_q_rdy = $urandom_range(99) < pqr;
    req1_q_rdy = $urandom_range(99) < pqr;
    #1;
    o        = m_owner;
    qro      = (o == 1) ? req1_q_rdy : req0_q_rdy;
    in_open  = (m_phase == 1) && (m_in < DIGITS);
    out_open = (m_phase == 1) && (m_out < DIGITS);
    e_dv     = in_open && rv[o];
    e_qr     = out_open && qro;
    chk("busy", busy, m_phase != 0);
    chk("op_done", op_done, m_phase == 2);
    if (m_phase != 0) chk("owner", owner, o);
    chk("div_vld", div_vld, e_dv);
    chk("div_q_rdy", div_q_rdy, e_qr);
    chk("req0_rdy", req0_rdy, in_open && o == 0 && div_rdy);
    chk("req1_rdy", req1_rdy, in_open && o == 1 && div_rdy);
    chk("req0_q_vld", req0_q_vld, out_open && o == 0 && qv);
    chk("req1_q_vld", req1_q_vld, out_open && o == 1 && qv);
    dfire = e_dv && div_rdy;
    qfire = qv && e_qr;
    if (dfire) begin
      chk("div_x", div_x, rx[o]);
      chk("div_d", div_d, rd[o]);
      rv[o] = 0; n_in++;
    end
    if (qfire) begin
      chk("q_data", (o == 1) ? req1_q : req0_q, qd);
      qv = 0; n_out++;
    end
    if (op_done) own_log.push_back(int'(owner));
    case (m_phase)
      0: if (rv[0] || rv[1]) begin
        m_owner = (rv[0] && rv[1]) ? 1 - m_last : (rv[1] ? 1 : 0);
        m_in = 0; m_out = 0; m_phase = 1;
      end
      1: begin
        m_in  += int'(dfire);
        m_out += int'(qfire);
        if (m_in == DIGITS && m_out == DIGITS) m_phase = 2;
      end
      default: begin
        chk("in_total", n_in, DIGITS);
        chk("out_total", n_out, DIGITS);
        n_in = 0; n_out = 0;
        m_last = m_owner; m_phase = 0;
      end
    endcase
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    asyn_reset = 1;
    drive_idle();
    model_reset();
    #3 chk_reset_outs("por");
    do_reset();

    // Lone requester 0, everything always ready.
    own_log.delete();
    repeat (22) cyc(100, 0, 100, 100, 100);
    chk("a_ops", own_log.size(), 1);
    if (own_log.size() > 0) chk("a_owner", own_log[0], 0);

    // Both requesting from reset: 0, then 1, then 0.
    do_reset();
    own_log.delete();
    for (int i = 0; i < 300 && own_log.size() < 3; i++) cyc(100, 100, 100, 100, 100);
    chk("b_ops", own_log.size(), 3);
    if (own_log.size() >= 3) begin
      chk("b_first", own_log[0], 0);
      chk("b_second", own_log[1], 1);
      chk("b_third", own_log[2], 0);
    end

    // Requester 0 owns; requester 1 toggles and quotients arrive randomly.
    do_reset();
    cyc(100, 0, 100, 0, 100);
    repeat (80) cyc(100, 50, 70, 70, 70, 1'b1);

    // Quotient held back until well after the inputs finish.
    do_reset();
    own_log.delete();
    repeat (21) cyc(100, 0, 100, 0, 100);
    chk("d_busy", busy, 1);
    chk("d_rdy0_held", req0_rdy, 0);
    repeat (20) cyc(100, 0, 100, 100, 100);
    chk("d_ops", own_log.size(), 1);

    // Random stalls on both sides.
    do_reset();
    own_log.delete();
    repeat (400) cyc(90, 30, 50, 60, 50);
    chk("e_ops_seen", own_log.size() > 1, 1);

    // Reset in the middle of an operation, then a fresh operation.
    do_reset();
    own_log.delete();
    for (int i = 0; i < 100 && m_in < 7; i++) cyc(100, 0, 100, 0, 100);
    chk("f_in7", m_in, 7);
    #2 asyn_reset = 1;
    #1 chk_reset_outs("f_mid");
    do_reset();
    repeat (40) cyc(100, 0, 100, 100, 100);
    chk("f_ops", own_log.size(), 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
